// File: rtl/aes_inv_round_col_pkg.sv
// Shared AES helpers: GF(2^8) multiplies, ShiftRows byte indexing and the
// column-serial round FSM encoding.
package aes_pkg;

  localparam int NCOL = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PROC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul9(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ a;
  endfunction

  function automatic logic [7:0] gmul11(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x2 ^ a;
  endfunction

  function automatic logic [7:0] gmul13(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ a;
  endfunction

  function automatic logic [7:0] gmul14(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

  // Source byte index feeding s'[r,c]; byte index is 4c+r, byte 0 at [127:120].
  function automatic int sr_src_index(input int r, input int c, input bit inverse);
    int src_col;
    if (inverse) src_col = (c + NCOL - r) % NCOL;
    else         src_col = (c + r) % NCOL;
    return 4 * src_col + r;
  endfunction

  function automatic logic [127:0] permute_rows(input logic [127:0] s, input bit inverse);
    logic [127:0] res;
    res = '0;
    for (int c = 0; c < NCOL; c++) begin
      for (int r = 0; r < 4; r++) begin
        res[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * sr_src_index(r, c, inverse) -: 8];
      end
    end
    return res;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    return permute_rows(s, 1'b0);
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    return permute_rows(s, 1'b1);
  endfunction

  function automatic logic [127:0] add_round_key(input logic [127:0] s, input logic [127:0] k);
    return s ^ k;
  endfunction

endpackage

// File: rtl/aes_inv_round_col_mix.sv
// Combinational InvMixColumns on one 32-bit column (a0 in the top byte).
module aes_inv_mix_column
  import aes_pkg::*;
(
  input  logic [31:0] col_in,
  output logic [31:0] col_out
);

  logic [7:0] a0, a1, a2, a3;

  assign a0 = col_in[31:24];
  assign a1 = col_in[23:16];
  assign a2 = col_in[15:8];
  assign a3 = col_in[7:0];

  // Each row uses the same 0e/0b/0d/09 coefficients rotated by its row number.
  assign col_out[31:24] = gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3);
  assign col_out[23:16] = gmul9(a0)  ^ gmul14(a1) ^ gmul11(a2) ^ gmul13(a3);
  assign col_out[15:8]  = gmul13(a0) ^ gmul9(a1)  ^ gmul14(a2) ^ gmul11(a3);
  assign col_out[7:0]   = gmul11(a0) ^ gmul13(a1) ^ gmul9(a2)  ^ gmul14(a3);

endmodule

// File: rtl/aes_inv_round_col.sv
// Column-serial AES-128 inverse round: InvShiftRows + AddRoundKey at accept,
// then one InvMixColumns column per cycle through a single shared unit.
module aes_inv_round_col
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         last_round,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out
);

  localparam logic [1:0] LAST_COL = 2'(NCOL - 1);

  state_t       state;
  logic [1:0]   col;
  logic [127:0] work;
  logic         last_q;
  logic [31:0]  col_sel;
  logic [31:0]  mix_out;
  logic [31:0]  col_new;
  logic [127:0] work_upd;
  logic         accept;

  assign in_ready  = !rst && (state == IDLE);
  assign out_valid = !rst && (state == DONE);
  assign accept    = in_valid && in_ready;
  assign state_out = out_valid ? work : '0;

  always_comb begin
    col_sel = work[127:96];
    case (col)
      2'd0:    col_sel = work[127:96];
      2'd1:    col_sel = work[95:64];
      2'd2:    col_sel = work[63:32];
      default: col_sel = work[31:0];
    endcase
  end

  aes_inv_mix_column u_mix (
    .col_in  (col_sel),
    .col_out (mix_out)
  );

  assign col_new = last_q ? col_sel : mix_out;

  always_comb begin
    work_upd = work;
    case (col)
      2'd0:    work_upd[127:96] = col_new;
      2'd1:    work_upd[95:64]  = col_new;
      2'd2:    work_upd[63:32]  = col_new;
      default: work_upd[31:0]   = col_new;
    endcase
  end

  // col parks on the last column through DONE and is only rewound from IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      col    <= '0;
      work   <= '0;
      last_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          col <= '0;
          if (accept) begin
            work   <= add_round_key(inv_shift_rows(state_in), round_key);
            last_q <= last_round;
            state  <= PROC;
          end
        end
        PROC: begin
          work <= work_upd;
          if (col == LAST_COL) begin
            state <= DONE;
          end else begin
            col <= col + 2'd1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_round_col.sv
// Directed bench for aes_inv_round_col using FIPS-197 derived vectors.
module tb_aes_inv_round_col;

  localparam logic [127:0] V1   = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
  localparam logic [127:0] R1   = 128'hd42711ae_e0bf98f1_b8b45de5_1e415230;
  localparam logic [127:0] V2   = 128'h04cbd34c_e0f826e5_4806819a_2866197a;
  localparam logic [127:0] R2   = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
  localparam logic [127:0] R3   = 128'h2bd8ee51_1f40670e_474ba21a_e1beadcf;
  localparam logic [127:0] KFF  = {128{1'b1}};
  localparam logic [127:0] KZ   = '0;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic [127:0] round_key;
  logic         last_round;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [127:0] vin  [3];
  logic [127:0] vkey [3];
  logic [127:0] vexp [3];
  logic         vlast[3];

  aes_inv_round_col dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .state_in   (state_in),
    .round_key  (round_key),
    .last_round (last_round),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .state_out  (state_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic drive_block(input logic [127:0] vec, input logic [127:0] key,
                             input logic last, output int acc, output bit ok);
    bit hs;
    hs  = 1'b0;
    acc = -1;
    state_in   = vec;
    round_key  = key;
    last_round = last;
    in_valid   = 1'b1;
    for (int i = 0; i < 20 && !hs; i++) begin
      @(negedge clk);
      if (in_ready) begin
        hs  = 1'b1;
        acc = cyc;
      end
      @(posedge clk);
      #1;
    end
    in_valid   = 1'b0;
    state_in   = ~vec;
    round_key  = ~key;
    last_round = ~last;
    ok = hs;
  endtask

  task automatic wait_out(output int oc, output logic [127:0] data, output bit ok);
    bit found;
    found = 1'b0;
    oc    = -1;
    data  = '0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (out_valid) begin
        found = 1'b1;
        oc    = cyc;
        data  = state_out;
      end
      @(posedge clk);
      #1;
    end
    ok = found;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    in_valid   = 1'b1;
    state_in   = V1;
    round_key  = KZ;
    last_round = 1'b1;
    out_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_in_ready got=%b want=0", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_out_valid got=%b want=0", out_valid);
    end
    checks++;
    if (state_out !== 128'h0) begin
      errors++;
      $display("[TB] FAIL reset_state_out got=%h want=0", state_out);
    end
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL post_reset_in_ready got=%b want=1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL post_reset_out_valid got=%b want=0", out_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_last_round_zero_key();
    int acc, oc;
    bit ok;
    logic [127:0] d;
    out_ready = 1'b1;
    drive_block(V1, KZ, 1'b1, acc, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL last_accept got=timeout want=accept");
    end
    wait_out(oc, d, ok);
    checks++;
    if (!ok || d !== R1) begin
      errors++;
      $display("[TB] FAIL last_data got=%h want=%h", d, R1);
    end
    checks++;
    if (oc - acc != 5) begin
      errors++;
      $display("[TB] FAIL last_latency got=%0d want=5", oc - acc);
    end
  endtask

  task automatic test_full_round();
    int acc, oc;
    bit ok;
    logic [127:0] d;
    out_ready = 1'b1;
    drive_block(V2, KZ, 1'b0, acc, ok);
    wait_out(oc, d, ok);
    checks++;
    if (!ok || d !== R2) begin
      errors++;
      $display("[TB] FAIL full_data got=%h want=%h", d, R2);
    end
    checks++;
    if (oc - acc != 5) begin
      errors++;
      $display("[TB] FAIL full_latency got=%0d want=5", oc - acc);
    end
  endtask

  task automatic test_key_add();
    int acc, oc;
    bit ok;
    logic [127:0] d;
    out_ready = 1'b1;
    drive_block(V1, KFF, 1'b1, acc, ok);
    wait_out(oc, d, ok);
    checks++;
    if (!ok || d !== R3) begin
      errors++;
      $display("[TB] FAIL key_data got=%h want=%h", d, R3);
    end
  endtask

  task automatic test_backpressure();
    int acc, oc, rel;
    bit ok;
    logic [127:0] d;
    out_ready = 1'b0;
    drive_block(V1, KZ, 1'b1, acc, ok);
    in_valid   = 1'b1;
    state_in   = V1;
    round_key  = KFF;
    last_round = 1'b1;
    wait_out(oc, d, ok);
    checks++;
    if (!ok || d !== R1) begin
      errors++;
      $display("[TB] FAIL bp_first got=%h want=%h", d, R1);
    end
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || state_out !== R1 || in_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_hold cycle=%0d got valid=%b ready=%b data=%h want valid=1 ready=0 data=%h",
                 i, out_valid, in_ready, state_out, R1);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || state_out !== R1) begin
      errors++;
      $display("[TB] FAIL bp_release got valid=%b data=%h want valid=1 data=%h", out_valid, state_out, R1);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    rel = cyc;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_next_accept got valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready);
    end
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    state_in   = '0;
    round_key  = '0;
    last_round = 1'b0;
    wait_out(oc, d, ok);
    checks++;
    if (!ok || d !== R3 || oc - rel != 5) begin
      errors++;
      $display("[TB] FAIL bp_second got=%h lat=%0d want=%h lat=5", d, oc - rel, R3);
    end
  endtask

  task automatic test_reset_mid();
    int acc, oc;
    bit ok, seen;
    logic [127:0] d;
    out_ready = 1'b1;
    drive_block(V2, KZ, 1'b0, acc, ok);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || state_out !== 128'h0) begin
      errors++;
      $display("[TB] FAIL mid_reset_outputs got valid=%b ready=%b data=%h want 0 0 0",
               out_valid, in_ready, state_out);
    end
    @(posedge clk);
    #1;
    rst  = 1'b0;
    seen = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || state_out !== 128'h0) begin
      errors++;
      $display("[TB] FAIL mid_after_reset got ready=%b data=%h want ready=1 data=0", in_ready, state_out);
    end
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen) begin
      errors++;
      $display("[TB] FAIL mid_no_output got out_valid seen=1 want 0");
    end
    @(posedge clk);
    #1;
    drive_block(V1, KZ, 1'b1, acc, ok);
    wait_out(oc, d, ok);
    checks++;
    if (!ok || d !== R1) begin
      errors++;
      $display("[TB] FAIL mid_next_block got=%h want=%h", d, R1);
    end
  endtask

  task automatic test_back_to_back();
    int idx, oidx;
    int acc[3];
    bit hs;
    vin[0] = V1; vkey[0] = KZ;  vlast[0] = 1'b1; vexp[0] = R1;
    vin[1] = V2; vkey[1] = KZ;  vlast[1] = 1'b0; vexp[1] = R2;
    vin[2] = V1; vkey[2] = KFF; vlast[2] = 1'b1; vexp[2] = R3;
    for (int k = 0; k < 3; k++) acc[k] = 0;
    idx  = 0;
    oidx = 0;
    out_ready  = 1'b1;
    state_in   = vin[0];
    round_key  = vkey[0];
    last_round = vlast[0];
    in_valid   = 1'b1;
    for (int i = 0; i < 60 && oidx < 3; i++) begin
      hs = 1'b0;
      @(negedge clk);
      if (out_valid) begin
        checks++;
        if (state_out !== vexp[oidx]) begin
          errors++;
          $display("[TB] FAIL b2b_data idx=%0d got=%h want=%h", oidx, state_out, vexp[oidx]);
        end
        oidx++;
      end
      if (in_valid && in_ready) begin
        acc[idx] = cyc;
        hs = 1'b1;
      end
      @(posedge clk);
      #1;
      if (hs) begin
        idx++;
        if (idx < 3) begin
          state_in   = vin[idx];
          round_key  = vkey[idx];
          last_round = vlast[idx];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    checks++;
    if (oidx != 3) begin
      errors++;
      $display("[TB] FAIL b2b_count got=%0d want=3", oidx);
    end
    checks++;
    if (acc[1] - acc[0] != 6) begin
      errors++;
      $display("[TB] FAIL b2b_interval01 got=%0d want=6", acc[1] - acc[0]);
    end
    checks++;
    if (acc[2] - acc[1] != 6) begin
      errors++;
      $display("[TB] FAIL b2b_interval12 got=%0d want=6", acc[2] - acc[1]);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    state_in   = '0;
    round_key  = '0;
    last_round = 1'b0;
    out_ready  = 1'b0;
    test_reset();
    test_last_round_zero_key();
    test_full_round();
    test_key_add();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_inv_round_col.md
# aes_inv_round_col

Column-serial AES-128 inverse-round datapath for the decryption path. It is the inverse counterpart of the encryption ShiftRows/MixColumns round stage. Per block it applies InvShiftRows, then AddRoundKey, then InvMixColumns, processing one 32-bit column per cycle. InvMixColumns is skipped on the final decryption round. InvSubBytes is external and runs upstream; it commutes with InvShiftRows.

## Interface
No parameters; the block is fixed at AES-128 (128-bit state, 4 columns).
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  input block valid
- in_ready  out  1  block accepts input this cycle
- state_in  in  128  state after InvSubBytes, FIPS-197 byte order: byte 0 = [127:120], column-major, s[r,c] = byte 4c+r
- round_key  in  128  round key, same byte order, sampled at accept
- last_round  in  1  1 = skip InvMixColumns (round 0 of inverse cipher), sampled at accept
- out_valid  out  1  state_out valid
- out_ready  in  1  downstream accepts state_out
- state_out  out  128  result, same byte order

## Operation
- Accept occurs when in_valid && in_ready.
- At accept, the block registers work = InvShiftRows(state_in) ^ round_key and latches last_round.
- InvShiftRows rule: s'[r,c] = s[r,(c-r) mod 4], so row r is rotated right by r byte positions.
- InvMixColumns per column: each output byte = 0e·a0 ^ 0b·a1 ^ 0d·a2 ^ 09·a3, with inputs rotated per row.
  - Arithmetic is in GF(2^8) with reduction polynomial 0x11b.
  - Multiplies are built from xtime chains only; no lookup tables.
- FSM states:
  - IDLE: in_ready = 1. On accept, go to PROC with col = 0.
  - PROC: at each edge, column col of work is replaced by InvMixColumns(col), or passed through unchanged if the latched last_round = 1. col increments 0→3. After col 3 is written, go to DONE.
  - DONE: out_valid = 1 and state_out = work. On out_ready, go to IDLE.
- state_out is held stable while out_valid && !out_ready.
- in_ready is 0 in PROC and DONE. The block never accepts a new block while holding a result.
- in_valid during PROC or DONE is ignored; the upstream stage must hold it under valid/ready rules.
- Reset mid-operation aborts the current block. The partial result is discarded and never presented.

## Timing
- Reset values while rst = 1: in_ready = 0, out_valid = 0, state_out = 0, FSM = IDLE, col = 0.
  - in_ready rises in the first cycle after rst deasserts.
- Latency: accept at edge E0, then columns written at edges E1..E4. out_valid is high from the cycle after E4.
- Minimum issue interval is 6 cycles: accept, 4 PROC cycles, 1 DONE cycle with out_ready = 1, then IDLE.
- If out_ready = 1 in the first DONE cycle, out_valid is high for exactly 1 cycle.
- col wraps 3→0 only through IDLE. The counter never runs while in DONE.
- If rst and a handshake occur in the same cycle, rst wins. Nothing is accepted or presented.
- last_round and round_key are used only as sampled at accept. Later changes to those inputs have no effect on the block in flight.

## Structure
- Shared package aes_pkg holds:
  - functions xtime, gmul9/11/13/14, inv_shift_rows(128b) and add_round_key;
  - FSM state enum {IDLE, PROC, DONE};
  - localparam NCOL = 4.
- The ShiftRows byte-index mapping belongs in the same package, so encrypt and decrypt use one indexing definition.
- One sub-module: aes_inv_mix_column, a combinational 32-bit-in/32-bit-out block, instantiated once and time-shared across columns by col.

## Test plan
- Last round with zero key:
  - Stimulus: state_in = d4bf5d30_e0b452ae_b84111f1_1e2798e5, key = 0, last_round = 1.
  - Required: state_out = d42711ae_e0bf98f1_b8b45de5_1e415230, out_valid exactly 5 cycles after accept.
- Full round with zero key:
  - Stimulus: state_in = 04cbd34c_e0f826e5_4806819a_2866197a, key = 0, last_round = 0.
  - Required: state_out = d4bf5d30_e0b452ae_b84111f1_1e2798e5 (FIPS-197 MixColumns example inverted).
- Key addition:
  - Stimulus: same input as the first scenario, key = all-ff, last_round = 1.
  - Required: state_out = 2bd8ee51_1f40670e_474ba21a_e1beadcf.
- Backpressure:
  - Stimulus: hold out_ready = 0 for 10 cycles after out_valid rises; drive in_valid = 1 throughout.
  - Required: state_out stable, in_ready = 0 throughout, a single output on release, next accept in the following cycle.
- Reset mid-operation:
  - Stimulus: assert rst during PROC at col = 2.
  - Required: out_valid never rises for that block, state_out = 0, in_ready = 1 the cycle after rst drops, next block correct.
- Back-to-back:
  - Stimulus: feed scenarios 1–3 consecutively with out_ready = 1.
  - Required: results in order, issue interval exactly 6 cycles.
